// File: rtl/timed_fifo_pkg.sv
// timed_fifo_pkg: shared types for the timed event queue (event layout, head-load states).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package timed_fifo_pkg;

    localparam int TIME_W    = 64;
    localparam int PAYLOAD_W = 64;

    // One queued event; timestamp occupies the upper half of the 128-bit word.
    typedef struct packed {
        logic [TIME_W-1:0]    timestamp;
        logic [PAYLOAD_W-1:0] payload;
    } event_t;

    // Head register load sequence.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ARMED = 2'd2
    } head_state_t;

endpackage

// File: rtl/event_fifo_ram.sv
// event_fifo_ram: simple dual-port event storage, one write port and one registered read port.
// Latency: read data valid 1 cycle after rd_en.
// Backpressure: none; the owner guarantees no write to a slot that is still queued.
module event_fifo_ram
    import timed_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  event_t        wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output event_t        rd_data
);

    event_t mem [DEPTH];

    // Write port plus registered read port; storage itself needs no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/timed_event_fifo.sv
// timed_event_fifo: queues timed events and fires the head on gpo_out when counter == timestamp.
// Latency: write to earliest counter_matched is 3 cycles; compare to strobe is 1 cycle.
// Backpressure: s_ready low while the array holds FIFO_DEPTH entries or flush is high; no pass-through.
// Build option: define TIMED_FIFO_LATE_FIRE_EN to also fire late heads on gpo_out/counter_matched.
module timed_event_fifo
    import timed_fifo_pkg::*;
#(
    parameter int FIFO_DEPTH     = 16,
    parameter int TIME_WIDTH     = 64,
    parameter int LATE_CNT_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          s_valid,
    input  logic [127:0]                  s_data,
    output logic                          s_ready,
    input  logic [63:0]                   counter,
    input  logic                          flush,
    input  logic                          error_clear,
    output logic [127:0]                  gpo_out,
    output logic                          counter_matched,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH)+1:0] fill_level,
    output logic                          late_error,
    output logic [LATE_CNT_WIDTH-1:0]     late_count,
    output logic [127:0]                  late_data
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = AW + 2;

    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   array_count;
    logic [CW-1:0]   count_next;
    head_state_t     state;
    event_t          head;
    logic            head_valid;
    event_t          rd_data;
    event_t          wr_event;
    logic [TIME_WIDTH-1:0] head_ts;

    logic wr_fire;
    logic rd_issue;
    logic head_match;
    logic head_late;
    logic head_resolve;
    logic fire_now;
    logic head_next;

    assign wr_event = s_data;
    assign head_ts  = head.timestamp;

    assign s_ready = (array_count < CW'(FIFO_DEPTH)) & ~flush;
    assign wr_fire = s_valid & s_ready;

    // Head comparison is only meaningful once the head register is armed.
    assign head_match   = (state == ARMED) & head_valid & (head_ts == counter);
    assign head_late    = (state == ARMED) & head_valid & (head_ts < counter);
    assign head_resolve = head_match | head_late;

    // Issue the array read when idle or when the current head leaves this cycle.
    assign rd_issue = ~flush & (array_count != '0) &
                      ((state == IDLE) | ((state == ARMED) & head_resolve));

`ifdef TIMED_FIFO_LATE_FIRE_EN
    assign fire_now = head_match | head_late;
`else
    assign fire_now = head_match;
`endif

    // An entry in flight (LOAD) is counted as the head so fill_level never dips mid-load.
    assign head_next  = ~flush & (rd_issue | (state == LOAD) | ((state == ARMED) & ~head_resolve));
    assign count_next = flush ? '0 : (array_count + CW'(wr_fire) - CW'(rd_issue));

    event_fifo_ram #(
        .DEPTH (FIFO_DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_fire),
        .wr_addr (wr_ptr),
        .wr_data (wr_event),
        .rd_en   (rd_issue),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    // Array pointers and occupancy; flush empties the array in one edge.
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            array_count <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_issue) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            array_count <= count_next;
        end
    end

    // Head-load FSM with registered fire outputs; a fire in the flush cycle still completes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state           <= IDLE;
            head            <= '0;
            head_valid      <= 1'b0;
            gpo_out         <= '0;
            counter_matched <= 1'b0;
        end else begin
            counter_matched <= 1'b0;
            if (fire_now) begin
                gpo_out         <= head;
                counter_matched <= 1'b1;
            end
            if (flush) begin
                state      <= IDLE;
                head_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (rd_issue) begin
                            state <= LOAD;
                        end
                    end
                    LOAD: begin
                        head       <= rd_data;
                        head_valid <= 1'b1;
                        state      <= ARMED;
                    end
                    ARMED: begin
                        if (head_resolve) begin
                            head_valid <= 1'b0;
                            state      <= rd_issue ? LOAD : IDLE;
                        end
                    end
                    default: begin
                        state      <= IDLE;
                        head_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Sticky late-error record; a late detection outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            late_error <= 1'b0;
            late_count <= '0;
            late_data  <= '0;
        end else if (head_late) begin
            late_error <= 1'b1;
            late_data  <= head;
            if (error_clear) begin
                late_count <= LATE_CNT_WIDTH'(1);
            end else if (!(&late_count)) begin
                late_count <= late_count + LATE_CNT_WIDTH'(1);
            end
        end else if (error_clear) begin
            late_error <= 1'b0;
            late_count <= '0;
            late_data  <= '0;
        end
    end

    // Occupancy status registered from next-state values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fill_level <= '0;
            empty      <= 1'b1;
        end else begin
            fill_level <= FW'(count_next) + FW'(head_next);
            empty      <= (count_next == '0) & ~head_next;
        end
    end

endmodule

// File: doc/timed_event_fifo.md
# timed_event_fifo

Timed event queue that sits directly upstream of each TTL/GPO output controller. It buffers 128-bit timed events as {timestamp[127:64], payload[63:0]} and compares the head timestamp against the global time counter. When they match, it presents the event on the controller's `gpo_in` bus with a one-cycle `counter_matched` strobe. Events whose time has already passed are counted and reported as late errors.

## Interface
Parameters:
- `FIFO_DEPTH`, 16: storage entries, excluding the head register; power of two, ≥ 4.
- `TIME_WIDTH`, 64: timestamp width; fixed at 64 by the entry format.
- `LATE_CNT_WIDTH`, 8: width of the saturating late-event counter.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-low reset (0 = reset).
- `s_valid`  in  1  write request.
- `s_data`  in  128  event {timestamp, payload}.
- `s_ready`  out  1  write can be accepted.
- `counter`  in  64  global time counter; increments by 1 per `clk`.
- `flush`  in  1  discard all queued events.
- `error_clear`  in  1  clears sticky error state.
- `gpo_out`  out  128  fired event; drives the controller's `gpo_in`.
- `counter_matched`  out  1  single-cycle fire strobe.
- `empty`  out  1  no head and no stored entries.
- `fill_level`  out  $clog2(FIFO_DEPTH)+2  stored entries plus the head.
- `late_error`  out  1  sticky; a late head was detected.
- `late_count`  out  `LATE_CNT_WIDTH`  saturating count of late events.
- `late_data`  out  128  last late event.

## Operation
- Storage is a simple dual-port array with a registered read, plus one head register (`head`, `head_valid`).
- **Write:** accepted when `s_valid & s_ready`.
  - `s_ready = (array_count < FIFO_DEPTH) & ~flush`.
- **Head load state machine**, states IDLE, LOAD, ARMED:
  - IDLE → LOAD when `array_count > 0`; the array read is issued.
  - LOAD → ARMED on the next edge; `head` is captured and `head_valid` is set.
  - ARMED compares `head.timestamp` against `counter`, unsigned.
    - Equal: fire. `gpo_out <= head`, `counter_matched <= 1`, `head_valid` clears, next state is LOAD if `array_count > 0`, else IDLE.
    - Head less than counter: late. `late_error <= 1`, `late_count` increments and saturates at all-ones, `late_data <= head`, head is discarded, and the state transitions as for a fire.
    - Greater: stay in ARMED.
- **Outputs:**
  - `gpo_out` holds the last fired value until the next fire.
  - `counter_matched` is high for exactly one cycle per fire.
- **Flush:** on the next edge, pointers, `array_count`, `head_valid`, and state (IDLE) are cleared.
  - A write in the same cycle is dropped (`s_ready` is low).
  - `gpo_out` and the error state are unaffected.
- **Error clear:** `error_clear` clears `late_error`, `late_count`, and `late_data`.
  - A late detection in the same cycle wins: the count is set to 1 and the flag stays set.
- **Timestamp width:** 64 bits. Counter wrap is unsupported.

## Timing
- Reset values: `s_ready`=1, `gpo_out`=0, `counter_matched`=0, `empty`=1, `fill_level`=0, `late_error`=0, `late_count`=0, `late_data`=0, state IDLE.
- Reset asserted mid-operation clears everything on that edge; queued events are lost.
- Write accepted at edge N:
  - Earliest LOAD is in cycle N+1.
  - `head_valid` is set from N+2.
  - Earliest `counter_matched` is at N+3, when `counter` equals the timestamp in cycle N+2.
- Compare-to-output latency is 1 cycle. The strobe asserts one cycle after the cycle in which `counter == timestamp`.
- Back-to-back fires need timestamp spacing ≥ 2. A spacing of 1 makes the second event late.
- Full boundary:
  - `s_ready` deasserts the cycle after `array_count` reaches `FIFO_DEPTH`.
  - A pop in cycle N reasserts `s_ready` in N+1. There is no same-cycle pass-through.
- `fill_level` and `empty` are registered and reflect the state after the previous edge.

## Configuration
- `TIMED_FIFO_LATE_FIRE_EN` defined:
  - A late head is fired like a match: `counter_matched` pulses and `gpo_out` = head.
  - The late error state is also updated.
- Undefined (default): late heads are dropped silently apart from the error state. `counter_matched` never pulses for them.

## Structure
- Package `timed_fifo_pkg`:
  - `event_t` packed struct {timestamp[63:0], payload[63:0]}.
  - `TIME_W` = 64, `PAYLOAD_W` = 64.
  - Head state enum {IDLE, LOAD, ARMED}.
- Sub-module `event_fifo_ram`: simple dual-port, one write port, one registered read port, depth `FIFO_DEPTH`, width 128. Pointers and count stay in the top level.

## Test plan
- Reset, then write {ts=100, payload=0x1} while counter runs from 0 → exactly one `counter_matched`, the cycle after counter=100; `gpo_out` payload = 0x1; `fill_level` returns to 0.
- Write events with ts=200, 202, 204 back-to-back → three strobes, each at ts+1; no late error.
- Write ts=300, 301 → first fires; second is late: `late_error`=1, `late_count`=1, `late_data.ts`=301. With `TIMED_FIFO_LATE_FIRE_EN`, a second strobe appears instead of no second strobe.
- Write FIFO_DEPTH+1 events with far timestamps and `s_valid` held → `s_ready` drops once the array is full; `fill_level`=FIFO_DEPTH+1; no writes are lost or duplicated.
- Assert `flush` with 5 queued events and `s_valid`=1 in the same cycle → `empty`=1 next cycle; no strobes follow; `gpo_out` unchanged.
- Assert `error_clear` in the same cycle as a new late detection → `late_error`=1, `late_count`=1.
